adc_scan_scheduler: RTL and testbench
=====================================

// Module: adc_scan_scheduler
// PURPOSE
//  Sequences the serial ADC reader: on a periodic tick, scans the enabled channels in ascending order.
//  For each channel it issues one conversion request and waits for completion.
//  Each result is forwarded tagged with its channel. Sits between the system logic and the ADC reader.
//  Timeouts and missed periods are flagged.
// PARAMETERS
//  NUM_CH   4      number of ADC channels scanned (1..8)
//  CH_W     2      width of channel index, clog2(NUM_CH), min 1
//  PERIOD   50000  clk cycles between scan starts (1 ms at 50 MHz), >= 2
//  TIMEOUT  20000  max clk cycles to wait for conv_done, >= 2
// PORTS
//  clk          in   1       50 MHz system clock, all logic on rising edge
//  rst          in   1       asynchronous, active-low reset
//  enable       in   1       1 = run periodic scans
//  ch_mask      in   NUM_CH  bit i = 1 -> channel i included in scan
//  clr_err      in   1       1-cycle pulse, clears timeout_err and overrun
//  conv_start   out  1       1-cycle pulse, request conversion to ADC reader
//  conv_ch      out  CH_W    channel for current request, stable start..done
//  conv_done    in   1       1-cycle pulse from reader, conv_data valid same cycle
//  conv_data    in   12      conversion result
//  result_valid out  1       1-cycle pulse, result_ch/result_data valid
//  result_ch    out  CH_W    channel of delivered result
//  result_data  out  12      delivered sample
//  scan_done    out  1       1-cycle pulse after last channel of a scan
//  busy         out  1       1 while a scan is in progress
//  timeout_err  out  1       sticky, a conversion timed out
//  overrun      out  1       sticky, a period tick arrived during a scan
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM = IDLE; counters 0.
//   - Reset mid-scan aborts immediately; no result or scan_done is produced.
//  Period counter:
//   - Held at 0 while enable = 0.
//   - Otherwise counts 0..PERIOD-1 and wraps.
//   - tick = (count == PERIOD-1); the first tick comes PERIOD cycles after enable rises.
//  FSM states: IDLE, WAIT_TICK, ISSUE, WAIT_DONE, NEXT.
//   IDLE:
//    - enable = 1 -> WAIT_TICK.
//   WAIT_TICK:
//    - enable = 0 -> IDLE.
//    - tick with ch_mask != 0 -> latch ch_mask into scan_mask; conv_ch = lowest set bit; busy = 1; -> ISSUE.
//    - tick with ch_mask == 0 -> ignored, stay.
//   ISSUE:
//    - conv_start = 1 for exactly this cycle; timeout counter cleared; -> WAIT_DONE.
//   WAIT_DONE:
//    - conv_done -> register conv_data; result_valid = 1 the next cycle with result_ch = conv_ch; -> NEXT.
//    - Timeout counter reaches TIMEOUT-1 without conv_done -> timeout_err = 1; no result; -> NEXT.
//   NEXT:
//    - enable = 0 -> busy = 0, no scan_done, -> IDLE.
//    - Else, if a higher set bit exists in scan_mask -> conv_ch = next set bit, -> ISSUE.
//    - Else -> scan_done = 1 for one cycle, busy = 0, -> WAIT_TICK.
//  Latency:
//   - tick -> conv_start: 2 cycles.
//   - conv_done -> result_valid: 1 cycle.
//   - Between conversions: conv_done -> next conv_start is 2 cycles.
//  Boundary conditions:
//   - ch_mask changes mid-scan have no effect until the next scan.
//   - conv_done outside WAIT_DONE is ignored.
//   - conv_done in the same cycle as the timeout -> treated as done, no error.
//   - enable = 0 during WAIT_DONE -> the conversion finishes or times out normally, then returns to IDLE (the reader frame is never cut).
//   - tick while busy -> overrun = 1 and the tick is dropped; the counter keeps running.
//   - clr_err in the same cycle as a new error event -> the error wins (flag ends at 1).
//   - Single-channel mask -> one conversion per scan; scan_done follows that result.
// TESTING  (bench uses PERIOD=100, TIMEOUT=50, NUM_CH=4)
//  1. ch_mask=4'b1011, reader model returns 12'hA00+ch after 20 cycles
//     -> results in order ch0=A00, ch1=A01, ch3=A03, then scan_done.
//  2. ch_mask=4'b0100, no conv_done -> conv_start once at ch2; timeout_err=1 after 50 cycles;
//     no result_valid; scan_done; next scan retries ch2.
//  3. Reader delay 40 cycles, mask=4'b1111 (scan longer than 100 cycles) -> overrun=1;
//     the next scan starts only at the tick after scan_done; clr_err pulse -> overrun=0.
//  4. Drop enable while ch1 is converting -> the ch1 result is still delivered;
//     no scan_done; FSM returns to IDLE; conv_start stays 0.
//  5. Assert rst mid WAIT_DONE, then a late conv_done arrives -> all outputs 0; no result_valid after release.
//  6. Flip ch_mask from 4'b0011 to 4'b1000 during a scan -> current scan still does ch0, ch1;
//     the next scan does only ch3.

Source files
------------

// File: rtl/adc_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : adc_scan_scheduler
//  Description : Periodic channel scanner for the serial ADC reader. On each
//                period tick it walks the enabled channels in ascending
//                order, issues one conversion per channel, forwards each
//                result tagged with its channel and flags timeouts/overruns.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int PERIOD  = 50000,
  parameter int TIMEOUT = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              clr_err,
  output logic              conv_start,
  output logic [CH_W-1:0]   conv_ch,
  input  logic              conv_done,
  input  logic [11:0]       conv_data,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_ch,
  output logic [11:0]       result_data,
  output logic              scan_done,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int c_PW = $clog2(PERIOD);
  localparam int c_TW = $clog2(TIMEOUT);
  localparam logic [c_PW-1:0] c_PERIOD_LAST  = c_PW'(PERIOD - 1);
  localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(TIMEOUT - 1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_WAIT_TICK = 3'd1;
  localparam logic [2:0] c_ISSUE     = 3'd2;
  localparam logic [2:0] c_WAIT_DONE = 3'd3;
  localparam logic [2:0] c_NEXT      = 3'd4;

  logic [2:0]        r_state;
  logic [c_PW-1:0]   r_pcnt;
  logic              r_tick;
  logic [c_TW-1:0]   r_tcnt;
  logic [NUM_CH-1:0] r_scan_mask;
  logic [CH_W-1:0]   r_conv_ch;
  logic              r_result_valid;
  logic [CH_W-1:0]   r_result_ch;
  logic [11:0]       r_result_data;
  logic              r_scan_done;
  logic              r_busy;
  logic              r_timeout_err;
  logic              r_overrun;

  logic [CH_W-1:0]   w_first_ch;
  logic              w_mask_any;
  logic [CH_W-1:0]   w_next_ch;
  logic              w_next_found;
  logic              w_timeout_evt;
  logic              w_overrun_evt;

  // Period counter; the tick is registered so the FSM sees it one cycle after
  // the terminal count, giving the two-cycle tick-to-request latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else if (!enable) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pcnt == c_PERIOD_LAST);
      r_pcnt <= (r_pcnt == c_PERIOD_LAST) ? '0 : r_pcnt + 1'b1;
    end
  end

  // Lowest enabled channel of the live mask, used when a scan starts.
  always_comb begin
    w_first_ch = '0;
    w_mask_any = |ch_mask;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) w_first_ch = CH_W'(i);
    end
  end

  // Next enabled channel above the current one in the latched scan mask.
  always_comb begin
    w_next_ch    = '0;
    w_next_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_scan_mask[i] && (i > int'(r_conv_ch))) begin
        w_next_ch    = CH_W'(i);
        w_next_found = 1'b1;
      end
    end
  end

  // A done arriving in the timeout cycle takes priority, so it is not an error.
  assign w_timeout_evt = (r_state == c_WAIT_DONE) && !conv_done && (r_tcnt == c_TIMEOUT_LAST);
  assign w_overrun_evt = r_tick && r_busy;

  // Scan sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= c_IDLE;
      r_tcnt         <= '0;
      r_scan_mask    <= '0;
      r_conv_ch      <= '0;
      r_result_valid <= 1'b0;
      r_result_ch    <= '0;
      r_result_data  <= '0;
      r_scan_done    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_scan_done    <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (enable) r_state <= c_WAIT_TICK;
        end
        c_WAIT_TICK: begin
          if (!enable) begin
            r_state <= c_IDLE;
          end else if (r_tick && w_mask_any) begin
            r_scan_mask <= ch_mask;
            r_conv_ch   <= w_first_ch;
            r_busy      <= 1'b1;
            r_state     <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_tcnt  <= '0;
          r_state <= c_WAIT_DONE;
        end
        c_WAIT_DONE: begin
          if (conv_done) begin
            r_result_valid <= 1'b1;
            r_result_ch    <= r_conv_ch;
            r_result_data  <= conv_data;
            r_state        <= c_NEXT;
          end else if (r_tcnt == c_TIMEOUT_LAST) begin
            r_state <= c_NEXT;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        c_NEXT: begin
          if (!enable) begin
            r_busy  <= 1'b0;
            r_state <= c_IDLE;
          end else if (w_next_found) begin
            r_conv_ch <= w_next_ch;
            r_state   <= c_ISSUE;
          end else begin
            r_scan_done <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= c_WAIT_TICK;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_timeout_evt)  r_timeout_err <= 1'b1;
      else if (clr_err)   r_timeout_err <= 1'b0;
      if (w_overrun_evt)  r_overrun <= 1'b1;
      else if (clr_err)   r_overrun <= 1'b0;
    end
  end

  assign conv_start   = (r_state == c_ISSUE);
  assign conv_ch      = r_conv_ch;
  assign result_valid = r_result_valid;
  assign result_ch    = r_result_ch;
  assign result_data  = r_result_data;
  assign scan_done    = r_scan_done;
  assign busy         = r_busy;
  assign timeout_err  = r_timeout_err;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_scheduler
//  Description : Self-checking bench for adc_scan_scheduler with a reader
//                model, an event monitor and a scan-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_scheduler;
  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 50;

  logic            clk = 1'b0;
  logic            rst, enable, clr_err, conv_done;
  logic [3:0]      ch_mask;
  logic [11:0]     conv_data;
  logic            conv_start, result_valid, scan_done, busy, timeout_err, overrun;
  logic [CH_W-1:0] conv_ch, result_ch;
  logic [11:0]     result_data;

  always #5 clk = ~clk;

  adc_scan_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .clr_err(clr_err),
    .conv_start(conv_start), .conv_ch(conv_ch), .conv_done(conv_done), .conv_data(conv_data),
    .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
    .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cyc = 0;
  int last_s0 = 0;

  // Reader model controls (written by the main sequence only)
  int          rd_delay = 0;
  logic [11:0] dbase = 12'h000;
  int          inj_req = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  ch;
    logic [11:0] data;
    logic        bsy;
  } ev_t;

  ev_t st_q[$];
  ev_t rs_q[$];
  ev_t sd_q[$];

  typedef struct {
    logic [3:0] mask;
    int         delay;
    int         nres;
    logic       terr;
  } vec_t;

  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log requests, results and scan completions with cycle stamps
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (conv_start)   st_q.push_back(ev_t'{cyc, conv_ch, 12'h000, busy});
      if (result_valid) rs_q.push_back(ev_t'{cyc, result_ch, result_data, busy});
      if (scan_done)    sd_q.push_back(ev_t'{cyc, 2'b00, 12'h000, busy});
    end
  end

  // Reader model: answers a request rd_delay cycles later (0 = never answers)
  initial begin : reader
    int         cnt;
    bit         pend;
    logic [1:0] pch;
    int         inj_seen;
    cnt = 0; pend = 0; pch = 0; inj_seen = 0;
    conv_done = 1'b0;
    conv_data = 12'h000;
    forever begin
      @(negedge clk);
      conv_done = 1'b0;
      if (!rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            conv_done = 1'b1;
            conv_data = dbase + 12'(pch);
            pend = 0;
          end
        end
        if (inj_req != inj_seen) begin
          inj_seen  = inj_req;
          conv_done = 1'b1;
          conv_data = 12'h5A5;
        end
        if (conv_start && rd_delay > 0) begin
          pend = 1;
          cnt  = rd_delay;
          pch  = conv_ch;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  task automatic wait_sd(input int n, input int budget, input string tag);
    int k = 0;
    while (sd_q.size() <= n && k < budget) begin
      step(1);
      k++;
    end
    chk({tag, " scan_done seen"}, 32'(sd_q.size() > n), 1);
  endtask

  task automatic wait_st(input int n, input int budget, input string tag);
    int k = 0;
    while (st_q.size() <= n && k < budget) begin
      step(1);
      k++;
    end
    chk({tag, " conv_start seen"}, 32'(st_q.size() > n), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " outputs zero"},
        32'({conv_start, conv_ch, result_valid, result_ch, result_data,
             scan_done, busy, timeout_err, overrun}), 0);
  endtask

  // Scan-level model: requests in ascending mask order, each answered after
  // 'delay' cycles (or abandoned TIMEOUT cycles after the request), the next
  // request two cycles after the answer/abandon, and scan_done likewise.
  task automatic check_scan(input string tag, input logic [3:0] mask, input int delay,
                            input logic [11:0] db, input int sidx, input int ridx,
                            input int didx);
    int chans[$];
    int n, stp, s0;
    bit answered;
    for (int c = 0; c < NUM_CH; c++) if (mask[c]) chans.push_back(c);
    n = chans.size();
    answered = (delay >= 1 && delay <= TIMEOUT);
    stp = answered ? delay + 2 : TIMEOUT + 2;
    chk({tag, " num requests"}, 32'(st_q.size() - sidx), 32'(n));
    chk({tag, " num results"}, 32'(rs_q.size() - ridx), answered ? 32'(n) : 0);
    if (st_q.size() - sidx >= n && n > 0 && sd_q.size() > didx) begin
      s0 = st_q[sidx].cyc;
      last_s0 = s0;
      chk({tag, " start on tick grid"}, 32'((s0 - en_cyc - PERIOD - 1) % PERIOD), 0);
      for (int k = 0; k < n; k++) begin
        chk({tag, " req ch"}, 32'(st_q[sidx + k].ch), 32'(chans[k]));
        chk({tag, " req cycle"}, 32'(st_q[sidx + k].cyc - s0), 32'(k * stp));
        chk({tag, " busy at req"}, 32'(st_q[sidx + k].bsy), 1);
      end
      if (answered && rs_q.size() - ridx >= n) begin
        for (int k = 0; k < n; k++) begin
          chk({tag, " res ch"}, 32'(rs_q[ridx + k].ch), 32'(chans[k]));
          chk({tag, " res data"}, 32'(rs_q[ridx + k].data), 32'(12'(db + 12'(chans[k]))));
          chk({tag, " res cycle"}, 32'(rs_q[ridx + k].cyc - s0), 32'(k * stp + delay + 1));
        end
      end
      chk({tag, " scan_done cycle"}, 32'(sd_q[didx].cyc - s0), 32'(n * stp));
      chk({tag, " busy at scan_done"}, 32'(sd_q[didx].bsy), 0);
    end
  endtask

  // Hard stop in case the sequence itself gets stuck
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sidx, ridx, didx, prev_s0, s, dly;
    logic [3:0] msk;

    vecs[0] = '{4'b1011, 20, 3, 1'b0};
    vecs[1] = '{4'b0100,  0, 0, 1'b1};
    vecs[2] = '{4'b0100,  0, 0, 1'b1};
    vecs[3] = '{4'b0001, 50, 1, 1'b0};
    vecs[4] = '{4'b0001, 51, 0, 1'b1};
    vecs[5] = '{4'b1000,  5, 1, 1'b0};
    vecs[6] = '{4'b1111,  1, 4, 1'b0};

    rst = 1'b1; enable = 1'b0; ch_mask = 4'b0000; clr_err = 1'b0;
    step(1);
    rst = 1'b0;
    step(2);
    check_zero("reset");
    rst = 1'b1;
    step(2);

    // Table: one scan per record, enable held high throughout
    prev_s0 = 0;
    for (int v = 0; v < 7; v++) begin
      ch_mask  = vecs[v].mask;
      rd_delay = vecs[v].delay;
      dbase    = 12'hA00;
      sidx = st_q.size(); ridx = rs_q.size(); didx = sd_q.size();
      if (v == 0) begin
        enable = 1'b1;
        en_cyc = cyc;
      end
      pulse_clr();
      wait_sd(didx, 300, $sformatf("vec%0d", v));
      check_scan($sformatf("vec%0d", v), vecs[v].mask, vecs[v].delay, 12'hA00, sidx, ridx, didx);
      chk($sformatf("vec%0d result count", v), 32'(rs_q.size() - ridx), 32'(vecs[v].nres));
      chk($sformatf("vec%0d timeout_err", v), 32'(timeout_err), 32'(vecs[v].terr));
      if (v == 0) chk("first start latency", 32'(last_s0 - en_cyc), 32'(PERIOD + 1));
      else        chk($sformatf("vec%0d period spacing", v), 32'(last_s0 - prev_s0), 32'(PERIOD));
      prev_s0 = last_s0;
    end

    // clr_err coincident with the timeout: the error must remain set
    ch_mask = 4'b0100; rd_delay = 0;
    sidx = st_q.size(); didx = sd_q.size();
    pulse_clr();
    wait_st(sidx, 200, "clr race");
    s = st_q[st_q.size() - 1].cyc;
    while (cyc < s + TIMEOUT) step(1);
    chk("clr race err before", 32'(timeout_err), 0);
    pulse_clr();
    chk("clr race err wins", 32'(timeout_err), 1);
    pulse_clr();
    chk("clr alone clears", 32'(timeout_err), 0);
    wait_sd(didx, 200, "clr race");

    // Overrun: four slow conversions outlast the period
    ch_mask = 4'b1111; rd_delay = 40; dbase = 12'hA00;
    sidx = st_q.size(); ridx = rs_q.size(); didx = sd_q.size();
    pulse_clr();
    chk("overrun before", 32'(overrun), 0);
    wait_sd(didx, 400, "overrun");
    check_scan("overrun", 4'b1111, 40, 12'hA00, sidx, ridx, didx);
    chk("overrun set", 32'(overrun), 1);
    chk("overrun no timeout", 32'(timeout_err), 0);
    ch_mask = 4'b0001; rd_delay = 5;
    prev_s0 = last_s0;
    sidx = st_q.size(); ridx = rs_q.size(); didx = sd_q.size();
    wait_sd(didx, 300, "after overrun");
    check_scan("after overrun", 4'b0001, 5, 12'hA00, sidx, ridx, didx);
    chk("dropped tick spacing", 32'(last_s0 - prev_s0), 32'(2 * PERIOD));
    pulse_clr();
    chk("overrun cleared", 32'(overrun), 0);

    // Mask change mid-scan applies to the following scan only
    ch_mask = 4'b0011; rd_delay = 10;
    sidx = st_q.size(); ridx = rs_q.size(); didx = sd_q.size();
    wait_st(sidx, 200, "mask flip");
    ch_mask = 4'b1000;
    wait_sd(didx, 200, "mask flip");
    check_scan("mask flip old", 4'b0011, 10, 12'hA00, sidx, ridx, didx);
    prev_s0 = last_s0;
    sidx = st_q.size(); ridx = rs_q.size(); didx = sd_q.size();
    wait_sd(didx, 200, "mask flip new");
    check_scan("mask flip new", 4'b1000, 10, 12'hA00, sidx, ridx, didx);
    chk("mask flip spacing", 32'(last_s0 - prev_s0), 32'(PERIOD));

    // Drop enable while ch1 converts: ch1 still delivered, scan abandoned
    ch_mask = 4'b1011; rd_delay = 20;
    sidx = st_q.size(); ridx = rs_q.size(); didx = sd_q.size();
    wait_st(sidx + 1, 300, "enable drop");
    step(5);
    enable = 1'b0;
    step(80);
    chk("enable drop requests", 32'(st_q.size() - sidx), 2);
    chk("enable drop results", 32'(rs_q.size() - ridx), 2);
    if (rs_q.size() - ridx >= 2) begin
      chk("enable drop ch1 ch", 32'(rs_q[ridx + 1].ch), 1);
      chk("enable drop ch1 data", 32'(rs_q[ridx + 1].data), 32'(12'hA01));
    end
    chk("enable drop no scan_done", 32'(sd_q.size() - didx), 0);
    chk("enable drop busy", 32'(busy), 0);

    // Randomized scans against the scan-level model
    enable = 1'b1;
    en_cyc = cyc;
    for (int r = 0; r < 8; r++) begin
      msk = 4'($urandom_range(1, 15));
      dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      ch_mask  = msk;
      rd_delay = dly;
      dbase    = 12'($urandom);
      sidx = st_q.size(); ridx = rs_q.size(); didx = sd_q.size();
      pulse_clr();
      wait_sd(didx, 500, $sformatf("rand%0d", r));
      check_scan($sformatf("rand%0d", r), msk, dly, dbase, sidx, ridx, didx);
      chk($sformatf("rand%0d timeout_err", r), 32'(timeout_err), 32'(dly == 0));
    end

    // Reset during WAIT_DONE, then a late conv_done after release
    ch_mask = 4'b0100; rd_delay = 0;
    sidx = st_q.size(); ridx = rs_q.size(); didx = sd_q.size();
    wait_st(sidx, 300, "reset mid");
    step(10);
    rst = 1'b0;
    step(1);
    check_zero("reset mid asserted");
    enable = 1'b0;
    step(1);
    rst = 1'b1;
    step(2);
    inj_req++;
    step(30);
    chk("reset mid requests", 32'(st_q.size() - sidx), 1);
    chk("reset mid no result", 32'(rs_q.size() - ridx), 0);
    chk("reset mid no scan_done", 32'(sd_q.size() - didx), 0);
    check_zero("reset mid after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
